// File: rtl/memory_bus_responder.sv
// memory_bus_responder: 8-bit CPU bus slave with 512-byte RAM, vector ROM bytes,
// a TX byte FIFO at 16'h8000 and its status register at 16'h8001.
// Optional feature macro: RESPONDER_WAIT_STATE_EN adds one wait state on RAM accesses.
module memory_bus_responder #(
    parameter logic [15:0] RESET_VECTOR = 16'h0200,
    parameter logic [15:0] IRQ_VECTOR   = 16'h0300,
    parameter logic [15:0] NMI_VECTOR   = 16'h0400,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] addressBusLow,
    input  logic [7:0] addressBusHigh,
    input  logic       busValid,
    input  logic       readWriteN,
    input  logic [7:0] dataBusWrite,
    output logic [7:0] dataBusRead,
    output logic       ready,
    output logic [7:0] txData,
    output logic       txValid,
    input  logic       txReady
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [15:0]      addr_s;
    logic             ram_hit_s;
    logic             tx_hit_s;
    logic             stat_hit_s;
    logic             ready_s;
    logic             rd_acc_s;
    logic             wr_acc_s;
    logic [7:0]       rd_mux_s;
    logic [7:0]       status_s;

    logic [7:0]       ram_r [0:511];
    logic [7:0]       fifo_r [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             push_req_s;
    logic             push_s;
    logic             ovf_set_s;
    logic             stat_rd_s;

    assign addr_s     = {addressBusHigh, addressBusLow};
    assign ram_hit_s  = (addr_s[15:9] == 7'd0);
    assign tx_hit_s   = (addr_s == 16'h8000);
    assign stat_hit_s = (addr_s == 16'h8001);

`ifdef RESPONDER_WAIT_STATE_EN
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wait_state_t;

    wait_state_t state_r;
    wait_state_t state_next_s;

    // Wait-state FSM register; reset parks it in IDLE so no access is pending.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // RAM hits in IDLE stall one cycle; WAIT always completes whatever is on the bus.
    always_comb begin
        state_next_s = ST_IDLE;
        ready_s      = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (busValid && ram_hit_s) begin
                    ready_s      = 1'b0;
                    state_next_s = ST_WAIT;
                end else begin
                    ready_s      = 1'b1;
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                ready_s      = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: begin
                ready_s      = 1'b1;
                state_next_s = ST_IDLE;
            end
        endcase
    end
`else
    assign ready_s = 1'b1;
`endif

    assign ready    = ready_s;
    assign rd_acc_s = busValid & ready_s & readWriteN;
    assign wr_acc_s = busValid & ready_s & ~readWriteN;

    // FIFO handshake terms; a push into a full FIFO is legal only alongside a pop.
    assign empty_s    = (count_r == {CNT_W{1'b0}});
    assign full_s     = (count_r == DEPTH_C);
    assign pop_s      = ~empty_s & txReady;
    assign push_req_s = wr_acc_s & tx_hit_s;
    assign push_s     = push_req_s & (~full_s | pop_s);
    assign ovf_set_s  = push_req_s & full_s & ~pop_s;
    assign stat_rd_s  = rd_acc_s & stat_hit_s;
    assign status_s   = {5'b00000, overflow_r, full_s, empty_s};
    assign txData     = fifo_r[rd_ptr_r];
    assign txValid    = ~empty_s;

    // Read data select: RAM, status, vector bytes, otherwise 8'hFF (includes TX data port).
    always_comb begin
        rd_mux_s = 8'hFF;
        if (ram_hit_s) begin
            rd_mux_s = ram_r[addr_s[8:0]];
        end else if (stat_hit_s) begin
            rd_mux_s = status_s;
        end else begin
            case (addr_s)
                16'hFFFA: rd_mux_s = NMI_VECTOR[7:0];
                16'hFFFB: rd_mux_s = NMI_VECTOR[15:8];
                16'hFFFC: rd_mux_s = RESET_VECTOR[7:0];
                16'hFFFD: rd_mux_s = RESET_VECTOR[15:8];
                16'hFFFE: rd_mux_s = IRQ_VECTOR[7:0];
                16'hFFFF: rd_mux_s = IRQ_VECTOR[15:8];
                default:  rd_mux_s = 8'hFF;
            endcase
        end
    end

    // RAM storage keeps its contents through reset; writes are blocked while nrst is low.
    always_ff @(posedge clk) begin
        if (nrst && wr_acc_s && ram_hit_s) begin
            ram_r[addr_s[8:0]] <= dataBusWrite;
        end else begin
            ram_r[addr_s[8:0]] <= ram_r[addr_s[8:0]];
        end
    end

    // FIFO storage; occupancy and pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_r[wr_ptr_r] <= dataBusWrite;
        end else begin
            fifo_r[wr_ptr_r] <= fifo_r[wr_ptr_r];
        end
    end

    // Read data register, FIFO pointers/occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dataBusRead <= 8'h00;
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            overflow_r  <= 1'b0;
        end else begin
            if (rd_acc_s) begin
                dataBusRead <= rd_mux_s;
            end else begin
                dataBusRead <= dataBusRead;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            // A fresh overflow wins over the clear-on-read of the status register.
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (stat_rd_s) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

endmodule

// File: tb/tb_memory_bus_responder.sv
// Directed self-checking bench for memory_bus_responder (default FIFO_DEPTH=4).
// Extra wait-state checks are compiled in when RESPONDER_WAIT_STATE_EN is defined.
module tb_memory_bus_responder;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] addressBusLow = 8'h00;
    logic [7:0] addressBusHigh = 8'h00;
    logic       busValid = 1'b0;
    logic       readWriteN = 1'b1;
    logic [7:0] dataBusWrite = 8'h00;
    logic [7:0] dataBusRead;
    logic       ready;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady = 1'b0;

    int passed = 0;
    int total  = 0;
    int waits  = 0;

`ifdef RESPONDER_WAIT_STATE_EN
    localparam int RAM_WAITS = 1;
`else
    localparam int RAM_WAITS = 0;
`endif

    memory_bus_responder dut (
        .clk            (clk),
        .nrst           (nrst),
        .addressBusLow  (addressBusLow),
        .addressBusHigh (addressBusHigh),
        .busValid       (busValid),
        .readWriteN     (readWriteN),
        .dataBusWrite   (dataBusWrite),
        .dataBusRead    (dataBusRead),
        .ready          (ready),
        .txData         (txData),
        .txValid        (txValid),
        .txReady        (txReady)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One bus access; returns the number of cycles ready stayed low (bounded).
    task automatic access(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                          output int nwait);
        @(negedge clk);
        addressBusHigh = a[15:8];
        addressBusLow  = a[7:0];
        readWriteN     = rw;
        dataBusWrite   = wd;
        busValid       = 1'b1;
        nwait          = 0;
        while (ready !== 1'b1 && nwait < 8) begin
            @(negedge clk);
            nwait++;
        end
        @(posedge clk);
        #1;
        busValid   = 1'b0;
        readWriteN = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        int w;
        access(a, 1'b1, 8'h00, w);
        check8(tag, dataBusRead, exp);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        int w;
        access(a, 1'b0, d, w);
    endtask

    task automatic drain(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_q [4];
        exp_q[0] = e0; exp_q[1] = e1; exp_q[2] = e2; exp_q[3] = e3;
        @(negedge clk);
        txReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check8({tag, "_valid"}, {7'd0, txValid}, 8'h01);
            check8({tag, "_data"}, txData, exp_q[i]);
            @(negedge clk);
        end
        check8({tag, "_empty"}, {7'd0, txValid}, 8'h00);
        txReady = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check8("rst_rdata", dataBusRead, 8'h00);
        check8("rst_txvalid", {7'd0, txValid}, 8'h00);
        check8("rst_ready", {7'd0, ready}, 8'h01);
        @(negedge clk);
        nrst = 1'b1;

        // Vector bytes
        rd("vec_fffc", 16'hFFFC, 8'h00);
        rd("vec_fffd", 16'hFFFD, 8'h02);
        rd("vec_fffe", 16'hFFFE, 8'h00);
        rd("vec_ffff", 16'hFFFF, 8'h03);
        rd("vec_fffb", 16'hFFFB, 8'h04);

        // RAM, unmapped space, TX data port read
        access(16'h01FF, 1'b0, 8'h5A, waits);
        check_int("ram_wr_waits", waits, RAM_WAITS);
        access(16'h01FF, 1'b1, 8'h00, waits);
        check8("ram_01ff", dataBusRead, 8'h5A);
        check_int("ram_rd_waits", waits, RAM_WAITS);
        wr(16'h0000, 8'hA5);
        wr(16'h0010, 8'hC3);
        rd("ram_0000", 16'h0000, 8'hA5);
        rd("unmapped_4000", 16'h4000, 8'hFF);
        wr(16'h4000, 8'h77);
        wr(16'hFFFC, 8'h99);
        rd("ram_01ff_keep", 16'h01FF, 8'h5A);
        rd("ram_0000_keep", 16'h0000, 8'hA5);
        rd("vec_fffc_keep", 16'hFFFC, 8'h00);
        rd("txport_read", 16'h8000, 8'hFF);
        access(16'h8001, 1'b1, 8'h00, waits);
        check8("status_empty", dataBusRead, 8'h01);
        check_int("status_waits", waits, 0);

        // Fill past capacity: fifth byte dropped, overflow sticky until read
        wr(16'h8000, 8'h11);
        check8("first_head", txData, 8'h11);
        wr(16'h8000, 8'h22);
        wr(16'h8000, 8'h33);
        wr(16'h8000, 8'h44);
        wr(16'h8000, 8'h55);
        rd("status_ovf", 16'h8001, 8'h06);
        rd("status_clr", 16'h8001, 8'h02);
        drain("pop1", 8'h11, 8'h22, 8'h33, 8'h44);
        rd("status_drained", 16'h8001, 8'h01);

        // Push into full FIFO with a simultaneous pop; pointers wrap
        wr(16'h8000, 8'h11);
        wr(16'h8000, 8'h22);
        wr(16'h8000, 8'h33);
        wr(16'h8000, 8'h44);
        txReady = 1'b1;
        wr(16'h8000, 8'h66);
        txReady = 1'b0;
        check8("fullpush_head", txData, 8'h22);
        rd("fullpush_status", 16'h8001, 8'h02);
        drain("pop2", 8'h22, 8'h33, 8'h44, 8'h66);

        // Push and pop request on an empty FIFO: push only
        txReady = 1'b1;
        wr(16'h8000, 8'h77);
        check8("emptypush_valid", {7'd0, txValid}, 8'h01);
        check8("emptypush_data", txData, 8'h77);
        @(posedge clk);
        #1;
        check8("emptypush_popped", {7'd0, txValid}, 8'h00);
        txReady = 1'b0;

        // Reset pulse: outputs reset, RAM preserved
        wr(16'h8000, 8'h12);
        rd("pre_rst_read", 16'h01FF, 8'h5A);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check8("rst2_rdata", dataBusRead, 8'h00);
        check8("rst2_txvalid", {7'd0, txValid}, 8'h00);
        @(negedge clk);
        nrst = 1'b1;
        rd("ram_after_rst", 16'h01FF, 8'h5A);
        rd("status_after_rst", 16'h8001, 8'h01);

`ifdef RESPONDER_WAIT_STATE_EN
        // Reset while an access sits in WAIT: nothing is written
        @(negedge clk);
        addressBusHigh = 8'h00;
        addressBusLow  = 8'h10;
        readWriteN     = 1'b0;
        dataBusWrite   = 8'h3C;
        busValid       = 1'b1;
        #1;
        check8("wait_stall", {7'd0, ready}, 8'h00);
        @(posedge clk);
        #1;
        check8("wait_ready", {7'd0, ready}, 8'h01);
        nrst     = 1'b0;
        busValid = 1'b0;
        #2;
        nrst       = 1'b1;
        readWriteN = 1'b1;
        rd("wait_rst_nowrite", 16'h0010, 8'hC3);
`else
        rd("ram_0010", 16'h0010, 8'hC3);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
